fle_param_frac: RTL and testbench

Parametrised fracturable logic element for the CLB `mode_default` tile. It holds a K-input LUT plus two output flip-flops, all configured by a serial `ccff` shift chain clocked on the fabric clock. The block tracks configuration progress with a small state machine and counter, and releases outputs only after a complete load. It replaces the fixed 4-input, 2-output fle and drops into the same CLB position, with `ccff_head`/`ccff_tail` daisy-chained between neighbouring fles.

---
 rtl/fle_param_frac.sv | 185 ++++++++++++++++++
 tb/tb_fle_param_frac.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fle_param_frac.sv
// rtl/fle_param_frac.sv - fracturable K-input LUT element with serial config chain and two output FFs
// Optional feature macro: FLE_CFG_PARITY_EN (adds an even-parity bit to the config chain and enables cfg_err)
module fle_param_frac #(
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         set,
  input  logic [K-1:0] fle_in,
  input  logic         fle_en,
  input  logic         ccff_en,
  input  logic         ccff_head,
  output logic         ccff_tail,
  output logic [1:0]   fle_out,
  output logic         cfg_done,
  output logic         cfg_err
);

  localparam int LUT_N = 1 << K;
`ifdef FLE_CFG_PARITY_EN
  localparam int CFG_W = LUT_N + 6;
`else
  localparam int CFG_W = LUT_N + 5;
`endif
  localparam int              CNT_W    = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

  // Field positions inside the configuration word.
  localparam int F_FRAC  = LUT_N;
  localparam int F_BYP0  = LUT_N + 1;
  localparam int F_BYP1  = LUT_N + 2;
  localparam int F_INIT0 = LUT_N + 3;
  localparam int F_INIT1 = LUT_N + 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CFG_W-1:0]  cfg;
  logic [1:0]        q;
  logic              load_init;
  logic              err_set;
  logic              err_clr;
  logic              parity_ok;

  logic [LUT_N-1:0]  lut_tbl;
  logic [K-1:0]      idx_lo;
  logic [K-1:0]      idx_hi;
  logic              lut0, lut1;
  logic              frac, byp0, byp1, init0, init1;
  logic              run;

  assign lut_tbl = cfg[LUT_N-1:0];
  assign frac    = cfg[F_FRAC];
  assign byp0    = cfg[F_BYP0];
  assign byp1    = cfg[F_BYP1];
  assign init0   = cfg[F_INIT0];
  assign init1   = cfg[F_INIT1];
  assign run     = (state_q == S_RUN);

  // Config chain: shifts in any state whenever ccff_en is high; tail is the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg <= '0;
    end else if (ccff_en) begin
      cfg <= {cfg[CFG_W-2:0], ccff_head};
    end
  end

  assign ccff_tail = cfg[CFG_W-1];

  // In fractured mode the top input picks nothing; the halves are addressed by the low K-1 bits.
  always_comb begin
    idx_lo = {1'b0, fle_in[K-2:0]};
    idx_hi = {1'b1, fle_in[K-2:0]};
    if (frac) begin
      lut0 = lut_tbl[idx_lo];
      lut1 = lut_tbl[idx_hi];
    end else begin
      lut0 = lut_tbl[fle_in];
      lut1 = lut_tbl[fle_in];
    end
  end

`ifdef FLE_CFG_PARITY_EN
  // The loaded word is valid only when the XOR over every bit, parity included, is zero.
  assign parity_ok = ~(^cfg);
`else
  assign parity_ok = 1'b1;
`endif

  // FSM state and load-length counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: count a shift burst, then accept it only if it was long enough and parity holds.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    load_init = 1'b0;
    err_set   = 1'b0;
    err_clr   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ccff_en) begin
          state_d = S_SHIFT;
          cnt_d   = CNT_W'(1);
          err_clr = 1'b1;
        end
      end
      S_SHIFT: begin
        if (ccff_en) begin
          if (cnt_q < CNT_FULL) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if ((cnt_q >= CNT_FULL) && parity_ok) begin
          state_d   = S_RUN;
          load_init = 1'b1;
        end else begin
          state_d = S_IDLE;
          err_set = (cnt_q >= CNT_FULL);
        end
      end
      S_RUN: begin
        if (ccff_en) begin
          state_d = S_SHIFT;
          cnt_d   = CNT_W'(1);
          err_clr = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef FLE_CFG_PARITY_EN
  logic err_q;

  // Sticky parity-failure flag, cleared when a new shift burst begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign cfg_err = err_q;
`else
  logic unused_err;
  assign unused_err = err_set | err_clr;
  assign cfg_err    = 1'b0;
`endif

  // Data FFs: init values on config acceptance, then LUT capture (or preset) while running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 2'b00;
    end else if (load_init) begin
      q <= {init1, init0};
    end else if (run && !ccff_en && fle_en) begin
      q <= set ? 2'b11 : {lut1, lut0};
    end
  end

  assign cfg_done   = run;
  assign fle_out[0] = run & (byp0 ? lut0 : q[0]);
  assign fle_out[1] = run & (byp1 ? lut1 : q[1]);

endmodule

// File: tb/tb_fle_param_frac.sv
// tb/tb_fle_param_frac.sv - self-checking bench for fle_param_frac (K=4), honours FLE_CFG_PARITY_EN
module tb_fle_param_frac;

  localparam int K     = 4;
  localparam int LUT_N = 1 << K;
`ifdef FLE_CFG_PARITY_EN
  localparam int CFG_W = LUT_N + 6;
`else
  localparam int CFG_W = LUT_N + 5;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         set;
  logic [K-1:0] fle_in;
  logic         fle_en;
  logic         ccff_en;
  logic         ccff_head;
  logic         ccff_tail;
  logic [1:0]   fle_out;
  logic         cfg_done;
  logic         cfg_err;

  fle_param_frac #(.K(K)) dut (
    .clk       (clk),
    .reset     (reset),
    .set       (set),
    .fle_in    (fle_in),
    .fle_en    (fle_en),
    .ccff_en   (ccff_en),
    .ccff_head (ccff_head),
    .ccff_tail (ccff_tail),
    .fle_out   (fle_out),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model: the bits that have been shifted in, the current burst length,
  // whether a valid configuration is live, the error flag and the two stored outputs.
  logic [CFG_W-1:0] m_cfg;
  int               m_burst;
  bit               m_run;
  bit               m_err;
  logic [1:0]       m_q;

  function automatic bit m_par_ok(input logic [CFG_W-1:0] c);
`ifdef FLE_CFG_PARITY_EN
    int ones = 0;
    for (int i = 0; i < CFG_W; i++) ones += int'(c[i]);
    return (ones % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [1:0] m_lut(input logic [CFG_W-1:0] c, input logic [K-1:0] x);
    int xi;
    int lo;
    xi = int'(x);
    if (c[LUT_N]) begin
      lo = xi % (LUT_N / 2);
      return {c[lo + LUT_N / 2], c[lo]};
    end
    return {c[xi], c[xi]};
  endfunction

  function automatic logic [CFG_W-1:0] make_cfg(input logic [LUT_N-1:0] lut, input bit fr,
                                                input bit b0, input bit b1, input bit i0, input bit i1);
    logic [CFG_W-1:0] v;
    v = '0;
    v[LUT_N-1:0] = lut;
    v[LUT_N]     = fr;
    v[LUT_N + 1] = b0;
    v[LUT_N + 2] = b1;
    v[LUT_N + 3] = i0;
    v[LUT_N + 4] = i1;
`ifdef FLE_CFG_PARITY_EN
    v[CFG_W-1] = ~m_par_ok(v);
`endif
    return v;
  endfunction

  task automatic model_reset();
    m_cfg   = '0;
    m_burst = 0;
    m_run   = 1'b0;
    m_err   = 1'b0;
    m_q     = 2'b00;
  endtask

  task automatic model_edge();
    if (ccff_en) begin
      m_cfg = {m_cfg[CFG_W-2:0], ccff_head};
      if (m_burst == 0) begin
        m_run = 1'b0;
        m_err = 1'b0;
      end
      m_burst++;
    end else if (m_burst > 0) begin
      if (m_burst >= CFG_W && m_par_ok(m_cfg)) begin
        m_run = 1'b1;
        m_q   = {m_cfg[LUT_N + 4], m_cfg[LUT_N + 3]};
      end else begin
        m_err = (m_burst >= CFG_W);
      end
      m_burst = 0;
    end else if (m_run && fle_en) begin
      m_q = set ? 2'b11 : m_lut(m_cfg, fle_in);
    end
  endtask

  function automatic logic [1:0] m_out();
    logic [1:0] l;
    if (!m_run) return 2'b00;
    l = m_lut(m_cfg, fle_in);
    return {m_cfg[LUT_N + 2] ? l[1] : m_q[1], m_cfg[LUT_N + 1] ? l[0] : m_q[0]};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_out"},  8'(fle_out),   8'(m_out()));
    chk({tag, "_done"}, 8'(cfg_done),  8'(m_run));
    chk({tag, "_err"},  8'(cfg_err),   8'(m_err));
    chk({tag, "_tail"}, 8'(ccff_tail), 8'(m_cfg[CFG_W-1]));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Shift n bits ending with v (MSB first); bits beyond CFG_W are random filler in front.
  task automatic load_bits(input logic [CFG_W-1:0] v, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      ccff_head = (i < CFG_W) ? v[i] : 1'($urandom);
      ccff_en   = 1'b1;
      tick();
      check_all({tag, "_sh"});
    end
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
    tick();
    check_all({tag, "_end"});
  endtask

  task automatic pulse_reset(input string tag);
    ccff_en = 1'b0;
    reset   = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    chk({tag, "_async_out"},  8'(fle_out),   8'h00);
    chk({tag, "_async_done"}, 8'(cfg_done),  8'h00);
    chk({tag, "_async_tail"}, 8'(ccff_tail), 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [CFG_W-1:0] v;
  int               len;

  initial begin
    reset     = 1'b1;
    set       = 1'b0;
    fle_in    = '0;
    fle_en    = 1'b0;
    ccff_en   = 1'b0;
    ccff_head = 1'b0;
    model_reset();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all("rst_rel");

    // AND4: byp0 set, output 1 registered with init1=1.
    v = make_cfg(16'h8000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    load_bits(v, CFG_W, "and4");
    fle_in = 4'hF;
    #1;
    check_all("and4_f");
    chk("and4_f_o0", 8'(fle_out[0]), 8'h01);
    chk("and4_f_o1", 8'(fle_out[1]), 8'h01);
    fle_en = 1'b1;
    tick();
    check_all("and4_cap");
    chk("and4_cap_o1", 8'(fle_out[1]), 8'h01);
    fle_en = 1'b0;
    fle_in = 4'h7;
    #1;
    check_all("and4_7");
    chk("and4_7_o0", 8'(fle_out[0]), 8'h00);

    // Asynchronous reset while running.
    pulse_reset("rst_run");

    // Fractured: low half XOR3, high half AND of the two low inputs, both bypassed.
    v = make_cfg(16'h8896, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    load_bits(v, CFG_W, "frac");
    for (int i = 0; i < 16; i++) begin
      fle_in = 4'(i);
      #1;
      check_all("frac_tbl");
    end
    fle_in = 4'b0011;
    #1;
    chk("frac_011", 8'(fle_out), 8'h02);

    // Short load: one bit missing.
    load_bits(v, CFG_W - 1, "short");
    chk("short_done", 8'(cfg_done), 8'h00);
    chk("short_err",  8'(cfg_err),  8'h00);
    chk("short_out",  8'(fle_out),  8'h00);

    // Registered path with preset, then hold with fle_en low.
    v = make_cfg(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    load_bits(v, CFG_W, "reg");
    set    = 1'b1;
    fle_en = 1'b1;
    tick();
    check_all("reg_set");
    chk("reg_set_q", 8'(fle_out), 8'h03);
    set = 1'b0;
    tick();
    check_all("reg_clr");
    chk("reg_clr_q", 8'(fle_out), 8'h00);
    fle_en = 1'b0;
    set    = 1'b1;
    tick();
    check_all("reg_hold");
    chk("reg_hold_q", 8'(fle_out), 8'h00);
    set = 1'b0;

    // Reset in the middle of a shift burst discards everything.
    for (int i = 0; i < 10; i++) begin
      ccff_head = 1'b1;
      ccff_en   = 1'b1;
      tick();
    end
    pulse_reset("rst_shift");
    tick();
    check_all("rst_shift_after");

    // Overshift keeps the last CFG_W bits.
    v = make_cfg(16'hA5C3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    load_bits(v, CFG_W + 7, "over");
    fle_in = 4'h5;
    #1;
    check_all("over_run");

`ifdef FLE_CFG_PARITY_EN
    // Bad parity then corrected reload.
    v = make_cfg(16'h1234, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    v[CFG_W-1] = ~v[CFG_W-1];
    load_bits(v, CFG_W, "par_bad");
    chk("par_bad_err",  8'(cfg_err),  8'h01);
    chk("par_bad_done", 8'(cfg_done), 8'h00);
    v[CFG_W-1] = ~v[CFG_W-1];
    load_bits(v, CFG_W, "par_ok");
    chk("par_ok_err",  8'(cfg_err),  8'h00);
    chk("par_ok_done", 8'(cfg_done), 8'h01);
`endif

    // Randomized loads and operation.
    for (int it = 0; it < 30; it++) begin
      v = make_cfg(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
`ifdef FLE_CFG_PARITY_EN
      if ($urandom_range(0, 4) == 0) v[CFG_W-1] = ~v[CFG_W-1];
`endif
      case ($urandom_range(0, 5))
        0:       len = CFG_W - $urandom_range(1, 4);
        1:       len = CFG_W + $urandom_range(1, 4);
        default: len = CFG_W;
      endcase
      load_bits(v, len, "rnd_load");
      for (int c = 0; c < 20; c++) begin
        fle_in = 4'($urandom);
        fle_en = 1'($urandom);
        set    = ($urandom_range(0, 3) == 0);
        #1;
        check_all("rnd_comb");
        tick();
        check_all("rnd_seq");
      end
      fle_en = 1'b0;
      set    = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
